// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: supervisor state encoding and parameter legality checks
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    function automatic bit timing_ok(input int rst_cycles, input int lock_timeout, input int stable_cycles);
        return rst_cycles >= 1 && stable_cycles >= 2 && lock_timeout > stable_cycles + 2;
    endfunction

    function automatic bit retry_ok(input int max_retry, input int cnt_w);
        return cnt_w >= 1 && cnt_w < 31 && max_retry >= 0 && max_retry < (1 << cnt_w);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer for signals asynchronous to clk_i
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the PLL reset, debounces lock and gates the downstream system reset
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRY);

    if (!timing_ok(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) begin : g_bad_timing
        $error("pll_lock_supervisor: need RST_CYCLES>=1, STABLE_CYCLES>=2, LOCK_TIMEOUT>STABLE_CYCLES+2");
    end
    if (!retry_ok(MAX_RETRY, CNT_W)) begin : g_bad_retry
        $error("pll_lock_supervisor: MAX_RETRY must fit in CNT_W bits");
    end

    state_e           state_q, state_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             lock_s, rst_done, timeout, stable_done;

    sync_2ff u_lock_sync (
        .clk_i(refclk),
        .rst_i(rst),
        .d_i  (pll_locked),
        .q_o  (lock_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            rcnt_q    <= '0;
            tmr_q     <= '0;
            stab_q    <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            tmr_q     <= tmr_d;
            stab_q    <= stab_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign rst_done    = rcnt_q == RW'(RST_CYCLES - 1);
    assign timeout     = tmr_q == TW'(LOCK_TIMEOUT - 1);
    assign stable_done = stab_q == SW'(STABLE_CYCLES - 1);

    // Timer keeps running through STABLE so a flapping lock still times out
    always_comb begin
        state_d = state_q;
        rcnt_d  = '0;
        tmr_d   = '0;
        stab_d  = '0;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            S_PLL_RST: begin
                rcnt_d  = rst_done ? '0 : rcnt_q + RW'(1);
                state_d = rst_done ? S_WAIT_LOCK : S_PLL_RST;
            end
            S_WAIT_LOCK, S_STABLE: begin
                tmr_d = tmr_q + TW'(1);
                if (state_q == S_STABLE && lock_s && stable_done) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end else if (timeout) begin
                    state_d = (retry_q == RETRY_MAX) ? S_FAIL : S_PLL_RST;
                    retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + CNT_W'(1);
                end else if (lock_s) begin
                    state_d = S_STABLE;
                    stab_d  = stab_q + SW'(1);
                end else begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_PLL_RST;
                    loss_d  = (&loss_q) ? loss_q : loss_q + CNT_W'(1);
                end
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_PLL_RST;
        endcase
    end

    always_comb begin
        pll_rst_d = state_d inside {S_PLL_RST, S_FAIL};
        sys_rst_d = state_d != S_RUN;
        ready_d   = state_d == S_RUN;
        fail_d    = state_d == S_FAIL;
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign state_o       = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scoreboard bench with directed scenarios and a randomized lock waveform
module tb_pll_lock_supervisor;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int STABLE_CYCLES = 16;
    localparam int MAX_RETRY     = 2;
    localparam int CNT_W         = 2;
    localparam int LOSS_MAX      = (1 << CNT_W) - 1;
    localparam int SEL_READY = 0, SEL_SYS = 1, SEL_STATE = 2;

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_locked = 1'b0;
    logic             pll_rst, sys_rst, ready, fail;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retry_cnt, lock_loss_cnt;

    pll_lock_supervisor #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst), .sys_rst(sys_rst),
        .ready(ready), .fail(fail), .state_o(state_o), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic             pll_rst;
        logic             sys_rst;
        logic             ready;
        logic             fail;
        logic [2:0]       st;
        logic [CNT_W-1:0] retry;
        logic [CNT_W-1:0] loss;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: phase 0..4, consecutive synchronized-lock run length inside the lock window
    int         m_phase = 0, m_age = 0, m_win = 0, m_run = 0, m_retry = 0, m_loss = 0;
    logic [1:0] m_hist = 2'b00;

    task automatic model_step(input logic r, input logic l);
        logic ls;
        exp_t e;
        if (r) begin
            m_phase = 0; m_age = 0; m_win = 0; m_run = 0; m_retry = 0; m_loss = 0; m_hist = 2'b00;
        end else begin
            ls = m_hist[1];
            m_hist = {m_hist[0], l};
            case (m_phase)
                0: begin
                    m_age++;
                    if (m_age == RST_CYCLES) begin m_phase = 1; m_win = 0; m_run = 0; end
                end
                1, 2: begin
                    m_win++;
                    m_run = ls ? m_run + 1 : 0;
                    if (m_run == STABLE_CYCLES) begin
                        m_phase = 3; m_retry = 0;
                    end else if (m_win == LOCK_TIMEOUT) begin
                        if (m_retry == MAX_RETRY) m_phase = 4;
                        else begin m_retry++; m_phase = 0; m_age = 0; end
                    end else begin
                        m_phase = (m_run > 0) ? 2 : 1;
                    end
                end
                3: if (!ls) begin
                    m_phase = 0; m_age = 0;
                    if (m_loss < LOSS_MAX) m_loss++;
                end
                default: ;
            endcase
        end
        e.pll_rst = (m_phase == 0 || m_phase == 4);
        e.sys_rst = (m_phase != 3);
        e.ready   = (m_phase == 3);
        e.fail    = (m_phase == 4);
        e.st      = 3'(m_phase);
        e.retry   = CNT_W'(m_retry);
        e.loss    = CNT_W'(m_loss);
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic r, input logic l);
        @(negedge refclk);
        rst = r;
        pll_locked = l;
        model_step(r, l);
    endtask

    task automatic dcheck(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int obs(input int sel);
        return sel == SEL_READY ? int'(ready) : sel == SEL_SYS ? int'(sys_rst) : int'(state_o);
    endfunction

    // Drives locked=l until the selected output reads want; e = edges since the first driven edge, -1 if never
    task automatic wait_edge(input logic l, input int sel, input int want, input int maxn, output int e);
        e = -1;
        for (int k = 1; k <= maxn; k++) begin
            tick(1'b0, l);
            if (obs(sel) == want) begin e = k - 1; break; end
        end
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pll_rst, sys_rst, ready, fail, state_o, retry_cnt, lock_loss_cnt};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: got pll_rst=%b sys_rst=%b ready=%b fail=%b state=%0d retry=%0d loss=%0d, expected pll_rst=%b sys_rst=%b ready=%b fail=%b state=%0d retry=%0d loss=%0d",
                             $time, a.pll_rst, a.sys_rst, a.ready, a.fail, a.st, a.retry, a.loss,
                             e.pll_rst, e.sys_rst, e.ready, e.fail, e.st, e.retry, e.loss);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   hi, e, falls, len;
        logic prev, l;

        repeat (3) tick(1'b1, 1'b0);
        dcheck("reset_state", state_o, 0);
        dcheck("reset_pll_rst", pll_rst, 1);
        dcheck("reset_ready", ready, 0);

        // Clean lock: lock rises 10 cycles after pll_rst falls
        hi = 0;
        for (int k = 0; k < 13; k++) begin tick(1'b0, 1'b0); hi += int'(pll_rst); end
        dcheck("pll_rst_pulse_len", hi, RST_CYCLES);
        wait_edge(1'b1, SEL_READY, 1, 30, e);
        dcheck("lock_to_ready", e, 18);
        dcheck("clean_sys_rst", sys_rst, 0);
        dcheck("clean_retry", retry_cnt, 0);

        // Glitchy lock: one-cycle drop at stable count 10
        repeat (2) tick(1'b1, 1'b0);
        repeat (13) tick(1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        wait_edge(1'b1, SEL_READY, 1, 40, e);
        dcheck("glitch_relock_to_ready", e, 18);

        // Lock loss in RUN, then re-lock
        wait_edge(1'b0, SEL_SYS, 1, 10, e);
        dcheck("loss_to_sys_rst", e, 3);
        dcheck("loss_pll_rst", pll_rst, 1);
        dcheck("loss_count_1", lock_loss_cnt, 1);
        wait_edge(1'b1, SEL_READY, 1, 60, e);
        dcheck("relock_ready", ready, 1);

        // Four more losses saturate the 2-bit counter
        for (int n = 0; n < 4; n++) begin
            wait_edge(1'b0, SEL_SYS, 1, 10, e);
            wait_edge(1'b1, SEL_READY, 1, 60, e);
        end
        dcheck("loss_saturated", lock_loss_cnt, LOSS_MAX);

        // Reset while in STABLE
        wait_edge(1'b0, SEL_SYS, 1, 10, e);
        wait_edge(1'b1, SEL_STATE, 2, 40, e);
        dcheck("reached_stable", state_o, 2);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        dcheck("rst_mid_stable_state", state_o, 0);
        dcheck("rst_mid_stable_loss", lock_loss_cnt, 0);
        dcheck("rst_mid_stable_sys_rst", sys_rst, 1);

        // Never locks
        tick(1'b1, 1'b0);
        falls = 0;
        prev = pll_rst;
        for (int k = 0; k < 300 && !fail; k++) begin
            tick(1'b0, 1'b0);
            if (prev && !pll_rst) begin dcheck("retry_at_pulse_end", retry_cnt, falls); falls++; end
            prev = pll_rst;
        end
        dcheck("fail_pulses", falls, MAX_RETRY + 1);
        dcheck("fail_flag", fail, 1);
        dcheck("fail_state", state_o, 4);
        repeat (30) tick(1'b0, 1'b1);
        dcheck("fail_sticky", state_o, 4);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        dcheck("fail_cleared", fail, 0);
        dcheck("fail_retry_cleared", retry_cnt, 0);

        // Randomized lock waveform with rare resets
        for (int n = 0; n < 1500; ) begin
            l = $urandom_range(0, 3) != 0;
            len = l ? $urandom_range(4, 70) : $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                tick($urandom_range(0, 199) == 0, l);
                n++;
            end
        end

        tick(1'b0, 1'b0);
        repeat (3) @(posedge refclk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
